packet_transmitter: RTL and testbench

Parametrised framing transmitter that serialises ping and nonce report packets onto a byte-wide UART transmit interface (tx_new/tx_data/tx_busy).
It snapshots the full nonce and bits-off values when a packet is accepted. Byte counting is internal, and it appends an optional XOR checksum before the footer.
It sits between the hash-search core/result registers and the UART transmitter.

---
 rtl/packet_transmitter.sv | 170 +++++++++++++++++
 tb/tb_packet_transmitter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : packet_transmitter
// Description : Frames ping and nonce report packets and serialises them one
//               byte at a time onto a UART transmit handshake
//               (tx_new/tx_data/tx_busy). Nonce packets carry a snapshot of
//               the nonce (MSB byte first), the bits-off score (LSB byte
//               first) and an optional XOR checksum ahead of the footer.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_transmitter #(
    parameter int         NONCE_BYTES = 16,
    parameter int         BITS_OFF_W  = 10,
    parameter int         CHECKSUM_EN = 1,
    parameter logic [7:0] HEADER_BYTE = 8'h64,
    parameter logic [7:0] FOOTER_BYTE = 8'h34
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tx_busy_i,
    input  logic                     send_nonce_i,
    input  logic                     send_ping_i,
    input  logic                     chip_enabled_i,
    input  logic [NONCE_BYTES*8-1:0] nonce_i,
    input  logic [BITS_OFF_W-1:0]    nonce_bits_off_i,
    output logic                     tx_new_o,
    output logic [7:0]               tx_data_o,
    output logic                     reset_nonce_waiting_o,
    output logic                     reset_ping_waiting_o,
    output logic                     busy_o
);

    localparam int BITS_OFF_BYTES = (BITS_OFF_W + 7) / 8;
    localparam int BOFF_PAD_W     = BITS_OFF_BYTES * 8;
    localparam int MAX_BYTES      = (NONCE_BYTES > BITS_OFF_BYTES) ? NONCE_BYTES : BITS_OFF_BYTES;
    localparam int CNT_W          = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PING  = 3'd2,
        S_NONCE = 3'd3,
        S_BOFF  = 3'd4,
        S_CSUM  = 3'd5,
        S_FOOT  = 3'd6
    } state_t;

    state_t                     state;
    logic                       kind_nonce;
    // Snapshots are consumed as shift registers: the nonce shifts left so the
    // next byte to send is always the top byte, bits-off shifts right so the
    // next byte is always the bottom byte.
    logic [NONCE_BYTES*8-1:0]   nonce_q;
    logic [BOFF_PAD_W-1:0]      boff_q;
    logic [CNT_W-1:0]           cnt;
    logic [7:0]                 csum;

    logic                       can_emit;
    logic [7:0]                 nonce_byte;
    logic [7:0]                 boff_byte;

    // Byte selection and the strobe-spacing rule (never two strobes running)
    always_comb begin
        can_emit   = !tx_busy_i && !tx_new_o;
        nonce_byte = nonce_q[NONCE_BYTES*8-1 -: 8];
        boff_byte  = boff_q[7:0];
    end

    // Packet sequencer with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                 <= S_IDLE;
            kind_nonce            <= 1'b0;
            nonce_q               <= '0;
            boff_q                <= '0;
            cnt                   <= '0;
            csum                  <= '0;
            tx_new_o              <= 1'b0;
            tx_data_o             <= '0;
            reset_nonce_waiting_o <= 1'b0;
            reset_ping_waiting_o  <= 1'b0;
            busy_o                <= 1'b0;
        end else begin
            tx_new_o              <= 1'b0;
            reset_nonce_waiting_o <= 1'b0;
            reset_ping_waiting_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (chip_enabled_i && !tx_busy_i && (send_nonce_i || send_ping_i)) begin
                        state  <= S_HDR;
                        busy_o <= 1'b1;
                        if (send_nonce_i) begin
                            nonce_q               <= nonce_i;
                            boff_q                <= BOFF_PAD_W'(nonce_bits_off_i);
                            csum                  <= '0;
                            cnt                   <= CNT_W'(NONCE_BYTES - 1);
                            kind_nonce            <= 1'b1;
                            reset_nonce_waiting_o <= 1'b1;
                        end else begin
                            kind_nonce            <= 1'b0;
                            reset_ping_waiting_o  <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (can_emit) begin
                        tx_new_o  <= 1'b1;
                        tx_data_o <= HEADER_BYTE;
                        state     <= kind_nonce ? S_NONCE : S_PING;
                    end
                end
                S_PING: begin
                    if (can_emit) begin
                        tx_new_o  <= 1'b1;
                        tx_data_o <= chip_enabled_i ? 8'h31 : 8'h30;
                        state     <= S_FOOT;
                    end
                end
                S_NONCE: begin
                    if (can_emit) begin
                        tx_new_o  <= 1'b1;
                        tx_data_o <= nonce_byte;
                        csum      <= csum ^ nonce_byte;
                        nonce_q   <= nonce_q << 8;
                        if (cnt == '0) begin
                            cnt   <= CNT_W'(BITS_OFF_BYTES - 1);
                            state <= S_BOFF;
                        end else begin
                            cnt   <= cnt - 1'b1;
                        end
                    end
                end
                S_BOFF: begin
                    if (can_emit) begin
                        tx_new_o  <= 1'b1;
                        tx_data_o <= boff_byte;
                        csum      <= csum ^ boff_byte;
                        boff_q    <= boff_q >> 8;
                        if (cnt == '0) begin
                            state <= (CHECKSUM_EN != 0) ? S_CSUM : S_FOOT;
                        end else begin
                            cnt   <= cnt - 1'b1;
                        end
                    end
                end
                S_CSUM: begin
                    if (can_emit) begin
                        tx_new_o  <= 1'b1;
                        tx_data_o <= csum;
                        state     <= S_FOOT;
                    end
                end
                S_FOOT: begin
                    if (can_emit) begin
                        tx_new_o  <= 1'b1;
                        tx_data_o <= FOOTER_BYTE;
                        state     <= S_IDLE;
                        busy_o    <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_transmitter
// Description : Scoreboard bench for packet_transmitter. Two instances share
//               all inputs: dut_a with checksum, dut_b without. Stimulus
//               pushes hand-computed bytes; monitors pop on every strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_transmitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_busy = 1'b0;
    logic        send_nonce = 1'b0;
    logic        send_ping = 1'b0;
    logic        chip_en = 1'b1;
    logic [31:0] nonce = '0;
    logic [9:0]  boff = '0;

    logic       a_new, a_rn, a_rp, a_busy;
    logic [7:0] a_data;
    logic       b_new, b_rn, b_rp, b_busy;
    logic [7:0] b_data;

    packet_transmitter #(.NONCE_BYTES(4), .BITS_OFF_W(10), .CHECKSUM_EN(1),
                         .HEADER_BYTE(8'h64), .FOOTER_BYTE(8'h34)) dut_a (
        .clk_i(clk), .rst_i(rst), .tx_busy_i(tx_busy), .send_nonce_i(send_nonce),
        .send_ping_i(send_ping), .chip_enabled_i(chip_en), .nonce_i(nonce),
        .nonce_bits_off_i(boff), .tx_new_o(a_new), .tx_data_o(a_data),
        .reset_nonce_waiting_o(a_rn), .reset_ping_waiting_o(a_rp), .busy_o(a_busy));

    packet_transmitter #(.NONCE_BYTES(4), .BITS_OFF_W(10), .CHECKSUM_EN(0),
                         .HEADER_BYTE(8'h64), .FOOTER_BYTE(8'h34)) dut_b (
        .clk_i(clk), .rst_i(rst), .tx_busy_i(tx_busy), .send_nonce_i(send_nonce),
        .send_ping_i(send_ping), .chip_enabled_i(chip_en), .nonce_i(nonce),
        .nonce_bits_off_i(boff), .tx_new_o(b_new), .tx_data_o(b_data),
        .reset_nonce_waiting_o(b_rn), .reset_ping_waiting_o(b_rp), .busy_o(b_busy));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int stamps[$];
    int a_strobes = 0, b_strobes = 0;
    int a_rn_cnt = 0, a_rp_cnt = 0;
    logic a_prev_new = 1'b0, b_prev_new = 1'b0, a_prev_rn = 1'b0, a_prev_rp = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expected bytes on every strobe of either instance
    always @(negedge clk) begin
        logic [7:0] e;
        if (a_new) begin
            check("a_gap", a_prev_new, 0);
            if (qa.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL a_unexpected: got %02h, want no strobe", a_data);
            end else begin
                e = qa.pop_front();
                check("a_byte", a_data, e);
            end
            stamps.push_back(cycle);
            a_strobes++;
        end
        if (b_new) begin
            check("b_gap", b_prev_new, 0);
            if (qb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL b_unexpected: got %02h, want no strobe", b_data);
            end else begin
                e = qb.pop_front();
                check("b_byte", b_data, e);
            end
            b_strobes++;
        end
        if (a_rn) begin
            check("rn_width", a_prev_rn, 0);
            a_rn_cnt++;
        end
        if (a_rp) begin
            check("rp_width", a_prev_rp, 0);
            a_rp_cnt++;
        end
        a_prev_new = a_new;
        b_prev_new = b_new;
        a_prev_rn  = a_rn;
        a_prev_rp  = a_rp;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic exp_both(input logic [7:0] v);
        qa.push_back(v);
        qb.push_back(v);
    endtask

    task automatic exp_nonce_pkt(input logic [7:0] n3, n2, n1, n0, b0, b1, cs);
        exp_both(8'h64); exp_both(n3); exp_both(n2); exp_both(n1); exp_both(n0);
        exp_both(b0); exp_both(b1); qa.push_back(cs); exp_both(8'h34);
    endtask

    task automatic request_nonce(input logic [31:0] n, input logic [9:0] b);
        int k;
        nonce = n; boff = b; send_nonce = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!a_rn && k < 20);
        check("rn_seen", a_rn, 1);
        send_nonce = 1'b0;
    endtask

    task automatic wait_ping_ack();
        int k;
        k = 0;
        do begin tick(); k++; end while (!a_rp && k < 200);
        check("rp_seen", a_rp, 1);
        send_ping = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while ((qa.size() != 0 || qb.size() != 0 || a_busy || b_busy) && k < 500) begin
            tick(); k++;
        end
        check(name, (k < 500), 1);
        tick(); tick();
    endtask

    initial begin
        int rn0, rp0, s0, sb0;
        // Reset state
        tick(); tick();
        check("rst_new",  {a_new, b_new}, 0);
        check("rst_data", {a_data, b_data}, 0);
        check("rst_busy", {a_busy, b_busy}, 0);
        check("rst_puls", {a_rn, a_rp, b_rn, b_rp}, 0);
        rst = 1'b0;
        tick();

        // Nonce packet, checksum on (a) and off (b), with timing checks
        stamps.delete();
        exp_nonce_pkt(8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h02, 8'hE3);
        request_nonce(32'h11223344, 10'h2A5);
        check("busy_hi", {a_busy, b_busy}, 2'b11);
        while (qb.size() != 0 && cycle < 2000) tick();
        tick();
        check("b_busy_after_foot", b_busy, 0);
        while (qa.size() != 0 && cycle < 2000) tick();
        tick();
        check("a_busy_after_foot", a_busy, 0);
        check("a_strobe_count", stamps.size(), 9);
        for (int i = 1; i < stamps.size(); i++) check("gap_len", stamps[i] - stamps[i-1], 2);
        check("rn_count", a_rn_cnt, 1);
        wait_done("t1_done");

        // Ping with chip enabled
        rp0 = a_rp_cnt;
        exp_both(8'h64); exp_both(8'h31); exp_both(8'h34);
        send_ping = 1'b1;
        wait_ping_ack();
        wait_done("ping_done");
        check("rp_count", a_rp_cnt - rp0, 1);

        // Ping with chip dropped between header and payload
        exp_both(8'h64); exp_both(8'h30); exp_both(8'h34);
        s0 = a_strobes;
        send_ping = 1'b1;
        wait_ping_ack();
        while (a_strobes == s0 && cycle < 5000) tick();
        chip_en = 1'b0;
        wait_done("ping_off_done");
        chip_en = 1'b1;

        // Simultaneous requests: nonce first, then the held ping
        rn0 = a_rn_cnt; rp0 = a_rp_cnt;
        exp_nonce_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h01, 8'h05);
        exp_both(8'h64); exp_both(8'h31); exp_both(8'h34);
        send_ping = 1'b1;
        request_nonce(32'h01020304, 10'h100);
        wait_ping_ack();
        wait_done("both_done");
        check("both_rn", a_rn_cnt - rn0, 1);
        check("both_rp", a_rp_cnt - rp0, 1);

        // Stall mid-nonce with input changes during the stall
        exp_nonce_pkt(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h00, 8'h23);
        s0 = a_strobes;
        request_nonce(32'hDEADBEEF, 10'h001);
        while (a_strobes < s0 + 3 && cycle < 8000) tick();
        tx_busy = 1'b1;
        nonce = 32'hFFFF_FFFF; boff = 10'h3FF;
        s0 = a_strobes; sb0 = b_strobes;
        repeat (20) tick();
        check("stall_a", a_strobes - s0, 0);
        check("stall_b", b_strobes - sb0, 0);
        tx_busy = 1'b0;
        wait_done("stall_done");

        // Asynchronous reset mid-nonce, then a fresh packet
        exp_nonce_pkt(8'h55, 8'h66, 8'h77, 8'h88, 8'hAA, 8'h00, 8'h00);
        s0 = a_strobes;
        request_nonce(32'h55667788, 10'h0AA);
        while (a_strobes < s0 + 4 && cycle < 10000) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_out_a", {a_new, a_data, a_rn, a_rp, a_busy}, 0);
        check("arst_out_b", {b_new, b_data, b_rn, b_rp, b_busy}, 0);
        qa.delete(); qb.delete();
        tick();
        rst = 1'b0;
        tick();
        exp_nonce_pkt(8'hA5, 8'hA5, 8'h0F, 8'h0F, 8'hFF, 8'h03, 8'hFC);
        request_nonce(32'hA5A50F0F, 10'h3FF);
        wait_done("fresh_done");

        // Chip disabled: requests ignored
        chip_en = 1'b0;
        rn0 = a_rn_cnt; rp0 = a_rp_cnt; s0 = a_strobes; sb0 = b_strobes;
        send_nonce = 1'b1; send_ping = 1'b1;
        repeat (30) tick();
        check("off_strobes", (a_strobes - s0) + (b_strobes - sb0), 0);
        check("off_pulses", (a_rn_cnt - rn0) + (a_rp_cnt - rp0), 0);
        check("off_busy", {a_busy, b_busy}, 0);
        send_nonce = 1'b0; send_ping = 1'b0; chip_en = 1'b1;
        tick();

        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
